// File: rtl/hdmi_palette_framegen.sv
// hdmi_palette_framegen
//   Streams a BPP-bit framebuffer from BRAM through a prefetch FIFO, maps each
//   index through a 2^BPP-entry 24-bit palette and drives registered RGB.
//   Optional feature macro: FRAMEGEN_PALETTE_WR_EN (writable palette). When it is
//   undefined the palette is fixed: index 0 = black, any other index = white.
module hdmi_palette_framegen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned BPP        = 1,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned BRAM_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              Clk_100MHz,
  input  logic              Reset,
  input  logic              PixEn,
  input  logic [9:0]        CounterX,
  input  logic [9:0]        CounterY,
  input  logic [BPP-1:0]    BRAM_Dout,
  output logic [ADDR_W-1:0] BRAM_addr,
  output logic              BRAM_en,
  input  logic              PalWe,
  input  logic [BPP-1:0]    PalAddr,
  input  logic [23:0]       PalData,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              Underflow
);

  localparam int unsigned NumPix = H_ACTIVE * V_ACTIVE;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + BRAM_LAT) + 1;
  localparam int unsigned PalN   = 1 << BPP;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);
  localparam logic [9:0]        HAct     = 10'(H_ACTIVE);
  localparam logic [9:0]        VAct     = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    StWaitFrame,
    StFetch,
    StDone
  } fetch_state_e;

  // ---------------------------------------------------------------------------
  // Timing events
  // ---------------------------------------------------------------------------
  logic fs;      // first vblank pixel: restart fetching for the next frame
  logic active;  // visible pixel that consumes one FIFO entry

  assign fs     = PixEn && (CounterY == VAct) && (CounterX == 10'd0);
  assign active = PixEn && (CounterX < HAct) && (CounterY < VAct);

  // ---------------------------------------------------------------------------
  // Fetch FSM and read issue
  // ---------------------------------------------------------------------------
  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BRAM_LAT-1:0] inflight_q, inflight_d;
  logic [CountW-1:0]   count_q;
  logic [CntW-1:0]     credit_used;
  logic                issue;

  // Slots already spoken for: FIFO entries plus reads still in the BRAM pipe.
  always_comb begin
    credit_used = CntW'(count_q);
    for (int i = 0; i < BRAM_LAT; i++) begin
      credit_used = credit_used + CntW'(inflight_q[i]);
    end
  end

  // A read issued in the FS cycle would belong to the old frame, so FS blocks it.
  assign issue     = (state_q == StFetch) && !fs && (credit_used < CntW'(FIFO_DEPTH));
  assign BRAM_en   = issue;
  assign BRAM_addr = addr_q;

  // Next-state: FS restarts from address 0; the last issued address ends the frame.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (fs) begin
      state_d = StFetch;
      addr_d  = '0;
    end else if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
      if (addr_q == LastAddr) begin
        state_d = StDone;
      end
    end
  end

  // Fetch state and address registers.
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      state_q <= StWaitFrame;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // In-flight valid bits shift towards the return slot; FS kills them all.
  always_comb begin
    inflight_d = '0;
    if (!fs) begin
      inflight_d[0] = issue;
      for (int i = 1; i < BRAM_LAT; i++) begin
        inflight_d[i] = inflight_q[i-1];
      end
    end
  end

  // In-flight valid shift register.
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  logic [BPP-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic            push, pop_req, pop, empty, underflow_evt;
  logic [BPP-1:0]  pop_idx;

  assign empty         = (count_q == '0);
  // Returns that coincide with FS belong to the previous frame.
  assign push          = inflight_q[BRAM_LAT-1] && !fs;
  assign pop_req       = active && (state_q != StWaitFrame);
  assign pop           = pop_req && !empty;
  assign underflow_evt = pop_req && empty;
  assign pop_idx       = fifo_mem_q[rptr_q];

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge Clk_100MHz) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= BRAM_Dout;
    end
  end

  // FIFO pointers and occupancy; FS flushes.
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (fs) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + CountW'(push) - CountW'(pop);
    end
  end

  // Sticky underflow; only reset clears it.
  logic uf_q;

  // Underflow flag register.
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      uf_q <= 1'b0;
    end else if (underflow_evt) begin
      uf_q <= 1'b1;
    end
  end

  assign Underflow = uf_q;

  // ---------------------------------------------------------------------------
  // Colour pipeline: stage 1 holds index/flags, stage 2 holds the looked-up RGB
  // ---------------------------------------------------------------------------
  logic           upd1_q, blank1_q, uf1_q;
  logic [BPP-1:0] idx1_q;
  logic [23:0]    pal_rd;
  logic [23:0]    rgb_q;

  // Stage 1: capture the popped index, or blank/underflow with index forced to 0.
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      upd1_q   <= 1'b0;
      blank1_q <= 1'b1;
      uf1_q    <= 1'b0;
      idx1_q   <= '0;
    end else begin
      upd1_q   <= PixEn;
      blank1_q <= !pop_req;
      uf1_q    <= underflow_evt;
      idx1_q   <= pop ? pop_idx : '0;
    end
  end

`ifdef FRAMEGEN_PALETTE_WR_EN
  logic [23:0] pal_q [PalN];

  // Writable palette; the combinational read sees the pre-write entry (read-first).
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < PalN; i++) begin
        pal_q[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
      end
    end else if (PalWe) begin
      pal_q[PalAddr] <= PalData;
    end
  end

  assign pal_rd = pal_q[idx1_q];
`else
  logic unused_pal;

  assign unused_pal = ^{PalWe, PalAddr, PalData, PalN[0]};
  assign pal_rd     = (idx1_q == '0) ? 24'h000000 : 24'hFFFFFF;
`endif

  // Stage 2: registered RGB, only updated on cycles that followed a PixEn.
  always_ff @(posedge Clk_100MHz or negedge Reset) begin
    if (!Reset) begin
      rgb_q <= '0;
    end else if (upd1_q) begin
      rgb_q <= (blank1_q || uf1_q) ? 24'h000000 : pal_rd;
    end
  end

  assign Red   = rgb_q[23:16];
  assign Green = rgb_q[15:8];
  assign Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_hdmi_palette_framegen.sv
// Self-checking bench for hdmi_palette_framegen with a queue-based frame model.
module tb_hdmi_palette_framegen;

  localparam int unsigned HA    = 16;
  localparam int unsigned VA    = 8;
  localparam int unsigned BPP   = 2;
  localparam int unsigned AW    = 7;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HT    = 20;
  localparam int unsigned VT    = 10;
  localparam int unsigned NPIX  = HA * VA;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pix_en = 1'b0;
  logic [9:0]     cx_in = '0;
  logic [9:0]     cy_in = '0;
  logic [BPP-1:0] bram_dout;
  logic [AW-1:0]  bram_addr;
  logic           bram_en;
  logic           pal_we = 1'b0;
  logic [BPP-1:0] pal_addr = '0;
  logic [23:0]    pal_data = '0;
  logic [7:0]     red, green, blue;
  logic           underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdmi_palette_framegen #(
    .H_ACTIVE  (HA),
    .V_ACTIVE  (VA),
    .BPP       (BPP),
    .ADDR_W    (AW),
    .BRAM_LAT  (LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clk_100MHz(clk),
    .Reset     (rst_n),
    .PixEn     (pix_en),
    .CounterX  (cx_in),
    .CounterY  (cy_in),
    .BRAM_Dout (bram_dout),
    .BRAM_addr (bram_addr),
    .BRAM_en   (bram_en),
    .PalWe     (pal_we),
    .PalAddr   (pal_addr),
    .PalData   (pal_data),
    .Red       (red),
    .Green     (green),
    .Blue      (blue),
    .Underflow (underflow)
  );

  // Framebuffer BRAM with LAT-cycle read latency.
  logic [BPP-1:0] fb [NPIX];
  logic [AW-1:0]  pa [LAT];

  initial for (int i = 0; i < int'(LAT); i++) pa[i] = '0;

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pa[i] <= pa[i-1];
    pa[0] <= bram_addr;
  end

  assign bram_dout = fb[pa[LAT-1]];

  // Reads issued since the most recent FS.
  int en_count;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_count <= 0;
    else if (pix_en && cy_in == VA && cx_in == 0) en_count <= 0;
    else if (bram_en) en_count <= en_count + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: queues of in-flight reads and FIFO contents
  // ---------------------------------------------------------------------------
  typedef enum int {MWait, MFetch, MDone} mstate_e;

  mstate_e     m_state;
  int          m_addr;
  int          m_fifo[$];
  int          infl_addr[$];
  int          infl_due[$];
  logic [23:0] m_pal [4];
  logic [23:0] m_rgb;
  bit          m_uf;
  bit          p_upd;
  bit          p_black;
  int          p_idx;
  int          cyc = 0;

  task automatic model_reset();
    m_state = MWait;
    m_addr  = 0;
    m_fifo.delete();
    infl_addr.delete();
    infl_due.delete();
    m_rgb   = '0;
    m_uf    = 1'b0;
    p_upd   = 1'b0;
    p_black = 1'b1;
    p_idx   = 0;
    m_pal[0] = 24'h000000;
    for (int i = 1; i < 4; i++) m_pal[i] = 24'hFFFFFF;
  endtask

  task automatic model_step();
    bit fs, act, issue, black;
    int idx;
    fs    = pix_en && cy_in == VA && cx_in == 0;
    act   = pix_en && cx_in < HA && cy_in < VA;
    issue = (m_state == MFetch) && !fs && (m_fifo.size() + infl_addr.size() < DEPTH);
    chk("bram_en", {31'b0, bram_en}, {31'b0, issue});
    if (issue) chk("bram_addr", {25'b0, bram_addr}, m_addr);
    black = 1'b1;
    idx   = 0;
    if (act && m_state != MWait) begin
      if (m_fifo.size() == 0) m_uf = 1'b1;
      else begin
        idx   = m_fifo.pop_front();
        black = 1'b0;
      end
    end
    if (infl_due.size() > 0 && infl_due[0] == cyc) begin
      int a;
      a = infl_addr.pop_front();
      void'(infl_due.pop_front());
      if (!fs) m_fifo.push_back(int'(fb[a]));
    end
    if (fs) begin
      m_fifo.delete();
      infl_addr.delete();
      infl_due.delete();
      m_addr  = 0;
      m_state = MFetch;
    end
    if (issue) begin
      infl_addr.push_back(m_addr);
      infl_due.push_back(cyc + LAT);
      if (m_addr == NPIX - 1) m_state = MDone;
      m_addr++;
    end
    // Lookup from the previous cycle lands in the output now, before this write.
    if (p_upd) m_rgb = p_black ? 24'h000000 : m_pal[p_idx];
`ifdef FRAMEGEN_PALETTE_WR_EN
    if (pal_we) m_pal[pal_addr] = pal_data;
`endif
    p_upd   = pix_en;
    p_black = black;
    p_idx   = idx;
    cyc++;
  endtask

  // Compare process: checks outputs every cycle, away from the clock edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_rgb", {8'b0, red, green, blue}, 0);
        chk("rst_underflow", {31'b0, underflow}, 0);
        chk("rst_bram_en", {31'b0, bram_en}, 0);
        model_reset();
      end else begin
        chk("rgb", {8'b0, red, green, blue}, {8'b0, m_rgb});
        chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
        model_step();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int cx = 0;
  int cy = 0;
  int vt_lim = VT;
  bit rnd_pal = 1'b0;

  task automatic cyc_drive(input bit en);
    @(negedge clk);
    pix_en   = en;
    pal_we   = rnd_pal && ($urandom_range(0, 7) == 0);
    pal_addr = BPP'($urandom_range(0, 3));
    pal_data = 24'($urandom);
    if (en) begin
      cx_in = 10'(cx);
      cy_in = 10'(cy);
      cx++;
      if (cx == HT) begin
        cx = 0;
        cy++;
        if (cy == vt_lim) cy = 0;
      end
    end else begin
      cx_in = 10'($urandom_range(0, 1023));
      cy_in = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic pix(input int gap);
    cyc_drive(1'b1);
    repeat (gap - 1) cyc_drive(1'b0);
  endtask

  task automatic pal_write(input int a, input logic [23:0] d);
    @(negedge clk);
    pix_en   = 1'b0;
    pal_we   = 1'b1;
    pal_addr = BPP'(a);
    pal_data = d;
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #2;
    chk("async_rst_rgb", {8'b0, red, green, blue}, 0);
    chk("async_rst_underflow", {31'b0, underflow}, 0);
    chk("async_rst_bram_en", {31'b0, bram_en}, 0);
    chk("async_rst_bram_addr", {25'b0, bram_addr}, 0);
    cyc_drive(1'b0);
    cyc_drive(1'b0);
    rst_n = 1'b1;
  endtask

  logic [23:0] lit [4];

  initial begin
`ifdef FRAMEGEN_PALETTE_WR_EN
    lit[0] = 24'h000000; lit[1] = 24'hFF0000; lit[2] = 24'h00FF00; lit[3] = 24'h0000FF;
`else
    lit[0] = 24'h000000; lit[1] = 24'hFFFFFF; lit[2] = 24'hFFFFFF; lit[3] = 24'hFFFFFF;
`endif
    for (int i = 0; i < int'(NPIX); i++) fb[i] = BPP'(i % 4);

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_red", {24'b0, red}, 0);
    chk("reset_green", {24'b0, green}, 0);
    chk("reset_blue", {24'b0, blue}, 0);
    chk("reset_underflow", {31'b0, underflow}, 0);
    chk("reset_bram_en", {31'b0, bram_en}, 0);
    chk("reset_bram_addr", {25'b0, bram_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Active-area pixels only, never an FS: nothing may be fetched.
    vt_lim = VA;
    cx = 0;
    cy = 0;
    repeat (2 * NPIX) pix(4);
    chk("no_fs_reads", en_count, 0);
    chk("no_fs_underflow", {31'b0, underflow}, 0);

    // Directed frame with pattern addr%4 and a four-colour palette.
    pal_write(0, 24'h000000);
    pal_write(1, 24'hFF0000);
    pal_write(2, 24'h00FF00);
    pal_write(3, 24'h0000FF);
    vt_lim = VT;
    cx = 0;
    cy = VA;
    for (int k = 0; k < int'(HT * VT); k++) begin
      if (cy == 0 && cx >= 1 && cx <= 4) chk("first_pixels", {8'b0, red, green, blue}, {8'b0, lit[cx-1]});
      pix(4);
    end
    chk("frame_reads", en_count, NPIX);
    chk("frame_underflow", {31'b0, underflow}, 0);

    // FS, reads in flight, FS again, then an immediate full-rate active line.
    pix(1);
    pix(1);
    cx = 0;
    cy = VA;
    pix(1);
    cx = 0;
    cy = 0;
    pix(1);
    pix(1);
    pix(1);
    chk("uf_pixel_black", {8'b0, red, green, blue}, 0);
    chk("uf_set", {31'b0, underflow}, 1);
    repeat (HT * VT) pix(1);
    chk("uf_sticky_after_fs", {31'b0, underflow}, 1);

    // Reset pulsed mid-line, then display resumes after the next FS.
    for (int k = 0; k < int'(2 * HT * VT); k++) begin
      if (cy == 2 && cx == 5) break;
      pix(4);
    end
    reset_pulse();
    repeat (2 * HT * VT) pix(4);
    chk("post_reset_underflow", {31'b0, underflow}, 0);

    // Randomized frames: density, counter jumps, palette writes, resets.
    reset_pulse();
    for (int i = 0; i < int'(NPIX); i++) fb[i] = BPP'($urandom_range(0, 3));
    rnd_pal = 1'b1;
    cx = 0;
    cy = VA;
    for (int f = 0; f < 8; f++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int k = 0; k < int'(HT * VT); k++) begin
        if ($urandom_range(0, 299) == 0) begin
          cx = $urandom_range(0, HT - 1);
          cy = $urandom_range(0, VT - 1);
        end
        if ($urandom_range(0, 599) == 0) reset_pulse();
        case (mode)
          0: pix(4);
          1: pix(2);
          2: pix(1);
          default: pix($urandom_range(1, 5));
        endcase
      end
    end
    rnd_pal = 1'b0;
    repeat (4) cyc_drive(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdmi_palette_framegen.md
# hdmi_palette_framegen

Parametrised successor to the 1-bit HDMI frame generator. Streams a BPP-bit-per-pixel framebuffer out of BRAM through a prefetch FIFO, maps each index through a 2^BPP-entry 24-bit palette and drives registered Red/Green/Blue to the HDMI encoder. It sits between the display timing counters, the framebuffer BRAM read port and the TMDS encoder. It runs on the 100 MHz system clock, qualified by a one-cycle pixel strobe.

## Interface
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- BPP, 1: bits per pixel, i.e. palette index width. Legal range 1..8.
- ADDR_W, 19: BRAM address width. Must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- BRAM_LAT, 2: BRAM read latency in cycles, from BRAM_en to valid BRAM_Dout. Legal range 1..4.
- FIFO_DEPTH, 8: prefetch FIFO depth. Must be a power of two and at least 4.
- Clk_100MHz  in  1  system clock; all logic runs on the rising edge.
- Reset  in  1  reset; asynchronous, active-low.
- PixEn  in  1  pixel strobe, one cycle per pixel.
- CounterX  in  10  horizontal display counter; sampled only when PixEn=1.
- CounterY  in  10  vertical display counter; sampled only when PixEn=1.
- BRAM_Dout  in  BPP  framebuffer read data.
- BRAM_addr  out  ADDR_W  framebuffer read address.
- BRAM_en  out  1  read strobe; high exactly in the cycles a read is issued.
- PalWe  in  1  palette write enable.
- PalAddr  in  BPP  palette write index.
- PalData  in  24  palette write data, packed {R,G,B}.
- Red, Green, Blue  out  8 each  pixel colour.
- Underflow  out  1  sticky flag: a pop was attempted while the FIFO was empty.

## Operation
- Frame start event (FS): PixEn=1 with CounterY==V_ACTIVE and CounterX==0, i.e. the first vblank pixel.
- Active pixel: PixEn=1 with CounterX<H_ACTIVE and CounterY<V_ACTIVE.
- Fetch FSM states: WAIT_FRAME, FETCH, DONE.
  - Reset enters WAIT_FRAME.
  - FS from any state: flush the FIFO, set the fetch address to 0, clear all in-flight valid bits, then go to FETCH.
  - In FETCH, a read is issued when (FIFO count + in-flight) < FIFO_DEPTH.
  - Each issued read drives BRAM_en=1, puts the address on BRAM_addr, then increments the address.
  - After issuing address H_ACTIVE*V_ACTIVE-1, go to DONE. DONE issues no reads.
- In-flight tracking: a BRAM_LAT-deep shift register of valid bits. A return is pushed into the FIFO only if its valid bit survives. Returns belonging to reads issued before an FS are discarded.
- Pop: every active pixel pops one FIFO entry, except while in WAIT_FRAME.
  - In WAIT_FRAME no pops occur and the output is black.
- Pop on an empty FIFO: the displayed index is forced to 0, the output is black, and Underflow is set. Underflow is cleared only by Reset.
- Non-active PixEn cycles and cycles with PixEn=0: no pop. The colour pipeline is fed "blank", which produces RGB 0.
- Palette is read-first. A simultaneous write and lookup of the same index returns the old entry.
- Palette reset contents: entry 0 = 24'h000000, all other entries = 24'hFFFFFF. With BPP=1 this reproduces the legacy black/white output.
- The FIFO never overflows, because the credit rule reserves a slot for every in-flight read.

## Timing
- Reset values: BRAM_addr=0, BRAM_en=0, Red/Green/Blue=0, Underflow=0, FIFO empty, fetch state WAIT_FRAME.
- BRAM_Dout is sampled exactly BRAM_LAT cycles after the BRAM_en cycle.
- Pixel latency: a pop in cycle t gives the palette read in t+1 and registered RGB in t+2. RGB holds until the next PixEn-driven update.
- Blank and underflow flags travel through the same 2-stage pipeline as the index.
- Fill rate: at most one read per cycle. Steady state is about 4 reads per PixEn at 25 MHz pixel rate, so the FIFO is full within FIFO_DEPTH+BRAM_LAT cycles after FS.
- FS coinciding with a BRAM return: the return is discarded. FS coinciding with a palette write: the write completes.
- Reset asserted mid-frame: all state clears asynchronously. Output stays black until the next FS.

## Configuration
- FRAMEGEN_PALETTE_WR_EN defined: the palette is writable through PalWe/PalAddr/PalData.
- FRAMEGEN_PALETTE_WR_EN undefined: the palette is fixed (index 0 = black, any nonzero index = white). PalWe, PalAddr and PalData are present but ignored, and no palette RAM is inferred.

## Test plan
- Reset, then PixEn every 4th cycle with no FS -> BRAM_en stays 0, RGB=0, Underflow=0 for a full frame.
- BPP=2, framebuffer pattern addr%4, palette {000000,FF0000,00FF00,0000FF}, one FS -> pixels 0..3 of line 0 produce FF0000? No: they produce 000000, FF0000, 00FF00, 0000FF in order. Each appears 2 cycles after its pop. The last read is issued at address 307199, then state is DONE.
- Hold PixEn=1 every cycle during an active line -> the FIFO drains and Underflow rises on the first empty pop, with that pixel output as 000000. Underflow stays 1 through later FS events.
- Assert FS while reads are in flight (BRAM_LAT=3) -> the stale returns are not pushed, and the first pixel after FS comes from address 0.
- PalWe to index 1 with 123456 in the same cycle a lookup of index 1 occurs -> the old colour is output. The next lookup gives 123456. With the macro undefined, the output stays FFFFFF.
- Reset pulsed mid-line -> all outputs are 0 immediately (asynchronous), and display resumes correctly after the next FS.
